// File: rtl/if_stage_q_pkg.sv
// ============================================================================
// if_pkg : shared types and defaults for the queued instruction-fetch stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package if_pkg;

    localparam int IF_ADDR_W     = 32;
    localparam int IF_INSTR_W    = 32;
    localparam int IF_PC_STEP    = 4;
    localparam int PC_ALIGN_BITS = $clog2(IF_PC_STEP);

    localparam logic [31:0] IF_RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [IF_ADDR_W-1:0]  pc;
        logic [IF_INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage_q_if.sv
// ============================================================================
// if_stage_q_if : instruction-memory read port and decode handshake bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface if_stage_q_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr
    );
endinterface

`default_nettype wire

// File: rtl/if_stage_q_fetch_queue.sv
// ============================================================================
// fetch_queue : generic DEPTH-entry FIFO with flush and same-cycle push/pop
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push_i,
    input  wire logic             pop_i,
    input  wire logic             flush_i,
    input  wire logic [WIDTH-1:0] data_i,
    output logic      [CNT_W-1:0] count_o,
    output logic      [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = pop_i & (count_q != '0);
    assign w_push = push_i & ((count_q != CNT_W'(DEPTH)) | w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage is reset too so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/if_stage_q.sv
// ============================================================================
// if_stage_q : PC register, fetch control and fetch queue toward decode.
// Optional perf counters enabled by defining IF_STAGE_Q_PERF_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module if_stage_q
    import if_pkg::*;
#(
    parameter int               ADDR_W       = IF_ADDR_W,
    parameter int               INSTR_W      = IF_INSTR_W,
    parameter int               DEPTH        = 2,
    parameter int               PC_STEP      = IF_PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(IF_RESET_VECTOR)
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    fetch_hold,
    input  wire logic                    redirect_valid,
    input  wire logic [ADDR_W-1:0]       redirect_target,
    if_stage_q_if.master                 bus,
`ifdef IF_STAGE_Q_PERF_EN
    output logic      [31:0]             perf_fetched,
    output logic      [31:0]             perf_flushed,
`endif
    output logic      [$clog2(DEPTH):0]  q_count
);

    localparam int                CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(PC_STEP - 1));

    logic [ADDR_W-1:0]         pc_q, pc_d;
    logic [CNT_W-1:0]          w_count;
    logic [ADDR_W+INSTR_W-1:0] w_head;
    logic                      w_pop;
    logic                      w_can_push;
    logic                      w_push;

    assign w_pop      = bus.out_valid & bus.out_ready;
    assign w_can_push = (w_count < CNT_W'(DEPTH)) | w_pop;
    assign w_push     = w_can_push & ~fetch_hold & ~redirect_valid;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_target & ALIGN_MASK;
        end else if (w_push) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= RESET_VECTOR;
        else      pc_q <= pc_d;
    end

    fetch_queue #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (redirect_valid),
        .data_i  ({pc_q, bus.imem_rdata}),
        .count_o (w_count),
        .head_o  (w_head)
    );

    // out_valid derives only from the registered occupancy, never from inputs.
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = (w_count != '0);
    assign bus.out_pc    = w_head[ADDR_W+INSTR_W-1:INSTR_W];
    assign bus.out_instr = w_head[INSTR_W-1:0];
    assign q_count       = w_count;

`ifdef IF_STAGE_Q_PERF_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] flushed_q, flushed_d;

    // Entries discarded by a redirect exclude the one handed off the same cycle.
    always_comb begin
        fetched_d = fetched_q;
        flushed_d = flushed_q;
        if (w_push) fetched_d = sat_add32(fetched_q, 32'd1);
        if (redirect_valid) flushed_d = sat_add32(flushed_q, 32'(w_count) - 32'(w_pop));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`endif

endmodule

`default_nettype wire
